// File: rtl/arb_mux_n.sv
// NCH-channel operand mux with forced-select or round-robin grant and a one-entry registered output stage.
// Optional macro ARB_MUX_XFER_CNT_EN adds a saturating output-handshake counter (Xfer_cnt, Cnt_clr).
module arb_mux_n #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                  CLK,
    input  logic                  Reset_n,
    input  logic [NCH*WIDTH-1:0]  In,
    input  logic [NCH-1:0]        In_valid,
    output logic [NCH-1:0]        In_ready,
    input  logic                  Mode,
    input  logic [SELW-1:0]       OP,
    output logic [WIDTH-1:0]      Out,
    output logic                  Out_valid,
    input  logic                  Out_ready,
`ifdef ARB_MUX_XFER_CNT_EN
    output logic [SELW-1:0]       Out_ch,
    output logic [15:0]           Xfer_cnt,
    input  logic                  Cnt_clr
`else
    output logic [SELW-1:0]       Out_ch
`endif
);

    localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WIDTH-1:0]  out_r;
    logic [SELW-1:0]   out_ch_r;
    logic [SELW-1:0]   ptr_r;

    logic              ld_s;
    logic              fixed_vld_s;
    logic              rr_vld_s;
    logic [SELW-1:0]   rr_gnt_s;
    logic [SELW:0]     rr_sum_s;
    logic [SELW:0]     rr_idx_s;
    logic              gnt_vld_s;
    logic [SELW-1:0]   gnt_s;
    logic [WIDTH-1:0]  sel_data_s;
    logic [NCH-1:0]    in_ready_s;

    assign ld_s = (state_r == EMPTY) | Out_ready;

    // Forced select: an OP value outside 0..NCH-1 matches no channel and so never grants.
    always_comb begin
        fixed_vld_s = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            fixed_vld_s = fixed_vld_s | ((OP == SELW'(i)) & In_valid[i]);
        end
    end

    // Round-robin scan from ptr; walking offsets downwards lets the nearest requester win.
    always_comb begin
        rr_vld_s = 1'b0;
        rr_gnt_s = '0;
        rr_sum_s = '0;
        rr_idx_s = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            rr_sum_s = {1'b0, ptr_r} + (SELW+1)'(k);
            rr_idx_s = (rr_sum_s >= NCH_W) ? (rr_sum_s - NCH_W) : rr_sum_s;
            rr_gnt_s = In_valid[rr_idx_s[SELW-1:0]] ? rr_idx_s[SELW-1:0] : rr_gnt_s;
            rr_vld_s = rr_vld_s | In_valid[rr_idx_s[SELW-1:0]];
        end
    end

    assign gnt_vld_s = ld_s & (Mode ? rr_vld_s : fixed_vld_s);
    assign gnt_s     = Mode ? rr_gnt_s : OP;

    // Granted channel's data and its one-hot ready, held off entirely during reset.
    always_comb begin
        sel_data_s = '0;
        in_ready_s = '0;
        for (int i = 0; i < NCH; i++) begin
            sel_data_s    = (gnt_s == SELW'(i)) ? In[i*WIDTH +: WIDTH] : sel_data_s;
            in_ready_s[i] = gnt_vld_s & Reset_n & (gnt_s == SELW'(i));
        end
    end

    assign In_ready = in_ready_s;

    // Output-stage occupancy register.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Occupancy next state: a load either refills the stage or drains it.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            EMPTY:   state_nxt_s = gnt_vld_s ? FULL : EMPTY;
            FULL:    state_nxt_s = ld_s ? (gnt_vld_s ? FULL : EMPTY) : FULL;
            default: state_nxt_s = EMPTY;
        endcase
    end

    // Data, source index and round-robin pointer; ptr only advances on round-robin grants.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            out_r    <= '0;
            out_ch_r <= '0;
            ptr_r    <= '0;
        end else if (gnt_vld_s) begin
            out_r    <= sel_data_s;
            out_ch_r <= gnt_s;
            if (Mode) begin
                ptr_r <= (gnt_s == SELW'(NCH - 1)) ? '0 : gnt_s + SELW'(1);
            end else begin
                ptr_r <= ptr_r;
            end
        end else begin
            out_r    <= out_r;
            out_ch_r <= out_ch_r;
            ptr_r    <= ptr_r;
        end
    end

    assign Out       = out_r;
    assign Out_ch    = out_ch_r;
    assign Out_valid = (state_r == FULL);

`ifdef ARB_MUX_XFER_CNT_EN
    logic [15:0] xfer_cnt_r;

    // Saturating handshake counter; clear wins over a same-cycle handshake.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            xfer_cnt_r <= 16'h0000;
        end else if (Cnt_clr) begin
            xfer_cnt_r <= 16'h0000;
        end else if ((state_r == FULL) && Out_ready && (xfer_cnt_r != 16'hFFFF)) begin
            xfer_cnt_r <= xfer_cnt_r + 16'h0001;
        end else begin
            xfer_cnt_r <= xfer_cnt_r;
        end
    end

    assign Xfer_cnt = xfer_cnt_r;
`endif

endmodule

// File: tb/tb_arb_mux_n.sv
// Self-checking bench for arb_mux_n: directed scenarios pinned by literals, then random traffic
// compared cycle by cycle against a transaction-level model of the output stage.
module tb_arb_mux_n;

    localparam int WIDTH = 16;
    localparam int NCH   = 4;
    localparam int SELW  = 2;

    logic                 clk;
    logic                 rst_n;
    logic [NCH*WIDTH-1:0] in_bus;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic                 mode;
    logic [SELW-1:0]      op;
    logic [WIDTH-1:0]     out;
    logic                 out_valid;
    logic                 out_ready;
    logic [SELW-1:0]      out_ch;
    logic                 cnt_clr;
    logic [15:0]          xfer_cnt;

    int n_chk;
    int n_fail;

    // Reference state: what the output stage holds, the rotation pointer, the handshake count.
    logic             m_valid;
    logic [WIDTH-1:0] m_out;
    int               m_ch;
    int               m_ptr;
    int               m_cnt;

    arb_mux_n #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
        .CLK       (clk),
        .Reset_n   (rst_n),
        .In        (in_bus),
        .In_valid  (in_valid),
        .In_ready  (in_ready),
        .Mode      (mode),
        .OP        (op),
        .Out       (out),
        .Out_valid (out_valid),
        .Out_ready (out_ready),
`ifdef ARB_MUX_XFER_CNT_EN
        .Out_ch    (out_ch),
        .Xfer_cnt  (xfer_cnt),
        .Cnt_clr   (cnt_clr)
`else
        .Out_ch    (out_ch)
`endif
    );

`ifndef ARB_MUX_XFER_CNT_EN
    assign xfer_cnt = 16'h0000;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] chan(input int i);
        return in_bus[i*WIDTH +: WIDTH];
    endfunction

    // Which channel the rules say is granted right now, or -1.
    function automatic int model_grant();
        if (!rst_n) return -1;
        if (m_valid && !out_ready) return -1;
        if (!mode) begin
            if (int'(op) < NCH && in_valid[op]) return int'(op);
            return -1;
        end
        for (int k = 0; k < NCH; k++) begin
            if (in_valid[(m_ptr + k) % NCH]) return (m_ptr + k) % NCH;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_out   = '0;
        m_ch    = 0;
        m_ptr   = 0;
        m_cnt   = 0;
    endtask

    task automatic model_step(input int g);
        logic hs;
        hs = m_valid && out_ready;
        if (cnt_clr) m_cnt = 0;
        else if (hs && m_cnt < 65535) m_cnt = m_cnt + 1;
        if (!m_valid || out_ready) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_out   = chan(g);
                m_ch    = g;
                if (mode) m_ptr = (g + 1) % NCH;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("out", {16'd0, out}, {16'd0, m_out});
        chk("out_ch", {30'd0, out_ch}, m_ch);
`ifdef ARB_MUX_XFER_CNT_EN
        chk("xfer_cnt", {16'd0, xfer_cnt}, m_cnt);
`endif
    endtask

    // One clock: inputs were set just after a negedge; ends on the following negedge.
    task automatic do_cycle();
        int g;
        logic [NCH-1:0] e;
        #1;
        g = model_grant();
        e = '0;
        if (g >= 0) e[g] = 1'b1;
        chk("in_ready", {28'd0, in_ready}, {28'd0, e});
        model_step(g);
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic set_data(input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                            input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] d3);
        in_bus = {d3, d2, d1, d0};
    endtask

    initial begin
        logic [WIDTH-1:0] dval [4];
        int rr_exp [6];
        int rr2_exp [3];
        n_chk = 0;
        n_fail = 0;
        dval = '{16'h0008, 16'h0004, 16'h0002, 16'h0001};
        rr_exp = '{0, 1, 2, 3, 0, 1};
        rr2_exp = '{3, 1, 3};
        rst_n = 1'b0;
        in_bus = '0;
        in_valid = '0;
        mode = 1'b0;
        op = '0;
        out_ready = 1'b0;
        cnt_clr = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out", {16'd0, out}, 32'd0);
        chk("reset_in_ready", {28'd0, in_ready}, 32'd0);
        rst_n = 1'b1;

        // Forced select across OP=3..0.
        set_data(16'h0008, 16'h0004, 16'h0002, 16'h0001);
        in_valid = 4'b1111;
        out_ready = 1'b1;
        for (int s = 3; s >= 0; s--) begin
            op = SELW'(s);
            #1;
            chk("fixed_in_ready", {28'd0, in_ready}, 32'd1 << s);
            do_cycle();
            chk("fixed_out", {16'd0, out}, {16'd0, dval[s]});
            chk("fixed_ch", {30'd0, out_ch}, s);
        end

        // Round-robin with everyone requesting wraps 0,1,2,3,0,1.
        mode = 1'b1;
        for (int s = 0; s < 6; s++) begin
            do_cycle();
            chk("rr_ch", {30'd0, out_ch}, rr_exp[s]);
            chk("rr_out", {16'd0, out}, {16'd0, dval[rr_exp[s]]});
        end

        // ptr is now 2; only ch1/ch3 requesting gives 3,1,3.
        in_valid = 4'b1010;
        for (int s = 0; s < 3; s++) begin
            do_cycle();
            chk("rr_sparse_ch", {30'd0, out_ch}, rr2_exp[s]);
        end

        // Stall with a held 0x0004 while OP wanders.
        mode = 1'b0;
        in_valid = 4'b1111;
        op = 2'd1;
        do_cycle();
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            op = SELW'((s * 2) % NCH);
            #1;
            chk("stall_in_ready", {28'd0, in_ready}, 32'd0);
            do_cycle();
            chk("stall_out", {16'd0, out}, 32'h0004);
            chk("stall_ch", {30'd0, out_ch}, 32'd1);
        end
        out_ready = 1'b1;
        op = 2'd3;
        do_cycle();
        chk("unstall_out", {16'd0, out}, 32'h0001);

        // Selected channel not valid: stage drains, data held.
        op = 2'd2;
        in_valid = 4'b1011;
        do_cycle();
        chk("nogrant_valid", {31'd0, out_valid}, 32'd0);
        chk("nogrant_out", {16'd0, out}, 32'h0001);

        // Asynchronous reset while full.
        in_valid = 4'b1111;
        op = 2'd0;
        do_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_out", {16'd0, out}, 32'd0);
        chk("async_rst_ready", {28'd0, in_ready}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        mode = 1'b1;
        do_cycle();
        chk("post_rst_ch", {30'd0, out_ch}, 32'd0);
        chk("post_rst_out", {16'd0, out}, 32'h0008);

`ifdef ARB_MUX_XFER_CNT_EN
        repeat (5) do_cycle();
        chk("cnt_five", {16'd0, xfer_cnt}, 32'd5);
        cnt_clr = 1'b1;
        do_cycle();
        chk("cnt_clr", {16'd0, xfer_cnt}, 32'd0);
        cnt_clr = 1'b0;
`endif

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NCH; i++) in_bus[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            in_valid  = NCH'($urandom);
            mode      = 1'($urandom);
            op        = SELW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cnt_clr   = ($urandom_range(0, 15) == 0);
            do_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
